// File: rtl/mem_wb_pipe_reg.sv
// MEM->WB stage register with valid/ready handshake, 2-entry skid buffer, flush and bubble zeroing.
// Optional performance counters are built when MEM_WB_PIPE_PERF_EN is defined.
module mem_wb_pipe_reg #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 4,
    parameter int RD_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [RD_W-1:0]   out_rd,
    output logic [1:0]        occupancy,
    output logic [31:0]       stall_cnt,
    output logic [15:0]       flush_drop_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [RD_W-1:0]   main_rd_q, main_rd_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [RD_W-1:0]   skid_rd_q, skid_rd_d;

    logic main_valid;
    logic skid_valid;
    logic in_fire;
    logic out_fire;

    assign main_valid = (state_q == ONE) || (state_q == FULL);
    assign skid_valid = (state_q == FULL);

    // in_ready comes straight from registered state, so out_ready never reaches it.
    assign in_ready  = ~skid_valid;
    assign out_valid = main_valid;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    assign out_data  = main_data_q;
    assign out_ctrl  = main_valid ? main_ctrl_q : '0;
    assign out_rd    = main_valid ? main_rd_q : '0;
    assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        main_rd_d   = main_rd_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_rd_d   = skid_rd_q;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    main_data_d = in_data;
                    main_ctrl_d = in_ctrl;
                    main_rd_d   = in_rd;
                    state_d     = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_data_d = in_data;
                    main_ctrl_d = in_ctrl;
                    main_rd_d   = in_rd;
                end else if (in_fire) begin
                    skid_data_d = in_data;
                    skid_ctrl_d = in_ctrl;
                    skid_rd_d   = in_rd;
                    state_d     = FULL;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    main_data_d = skid_data_q;
                    main_ctrl_d = skid_ctrl_q;
                    main_rd_d   = skid_rd_q;
                    state_d     = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            main_rd_q   <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_rd_q   <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            main_rd_q   <= main_rd_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_rd_q   <= skid_rd_d;
        end
    end

`ifdef MEM_WB_PIPE_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_drop_cnt_q, flush_drop_cnt_d;
    logic [16:0] drop_sum;

    assign drop_sum = {1'b0, flush_drop_cnt_q} + {15'd0, occupancy};

    // Both counters saturate rather than wrap.
    always_comb begin
        stall_cnt_d      = stall_cnt_q;
        flush_drop_cnt_d = flush_drop_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (flush) begin
            flush_drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q      <= '0;
            flush_drop_cnt_q <= '0;
        end else begin
            stall_cnt_q      <= stall_cnt_d;
            flush_drop_cnt_q <= flush_drop_cnt_d;
        end
    end

    assign stall_cnt      = stall_cnt_q;
    assign flush_drop_cnt = flush_drop_cnt_q;
`else
    assign stall_cnt      = '0;
    assign flush_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Scoreboard bench for mem_wb_pipe_reg: stimulus pushes expected entries, a negedge monitor pops and compares.
module tb_mem_wb_pipe_reg;

    localparam int DATA_W = 128;
    localparam int CTRL_W = 4;
    localparam int RD_W   = 5;
    localparam int ENT_W  = DATA_W + CTRL_W + RD_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic [RD_W-1:0]   in_rd;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [RD_W-1:0]   out_rd;
    logic [1:0]        occupancy;
    logic [31:0]       stall_cnt;
    logic [15:0]       flush_drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    logic [ENT_W-1:0] sb[$];

    mem_wb_pipe_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .RD_W(RD_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .in_rd(in_rd), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ctrl(out_ctrl), .out_rd(out_rd), .occupancy(occupancy),
        .stall_cnt(stall_cnt), .flush_drop_cnt(flush_drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: model the accepted entry (or the flush/reset discard) at the edge.
    task automatic step();
        logic rdy;
        rdy = in_ready;
        @(posedge clk);
        if (!reset || flush) sb.delete();
        else if (in_valid && rdy) sb.push_back({in_data, in_ctrl, in_rd});
        #1;
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c, input logic [RD_W-1:0] r);
        in_valid = v;
        in_data  = d;
        in_ctrl  = c;
        in_rd    = r;
    endtask

    task automatic chk_counters(input string tag, input logic [31:0] exp_stall, input logic [15:0] exp_drop);
`ifdef MEM_WB_PIPE_PERF_EN
        chk({tag, "_stall_cnt"}, DATA_W'(stall_cnt), DATA_W'(exp_stall));
        chk({tag, "_flush_drop_cnt"}, DATA_W'(flush_drop_cnt), DATA_W'(exp_drop));
`else
        if (exp_stall == 32'hFFFF_FFFF && exp_drop == 16'hFFFF) n_checks += 0;
        chk({tag, "_stall_cnt"}, DATA_W'(stall_cnt), '0);
        chk({tag, "_flush_drop_cnt"}, DATA_W'(flush_drop_cnt), '0);
`endif
    endtask

    // Monitor: occupancy tracks the model, bubbles are zeroed, each out_fire pops in order.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            chk("occupancy_vs_model", DATA_W'(occupancy), DATA_W'(sb.size()));
            if (!out_valid) begin
                chk("bubble_ctrl", DATA_W'(out_ctrl), '0);
                chk("bubble_rd", DATA_W'(out_rd), '0);
            end else if (out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got data %0h with empty expectation queue", out_data);
                end else begin
                    logic [ENT_W-1:0] e;
                    e = sb.pop_front();
                    chk("out_data", out_data, e[ENT_W-1 -: DATA_W]);
                    chk("out_ctrl", DATA_W'(out_ctrl), DATA_W'(e[RD_W +: CTRL_W]));
                    chk("out_rd", DATA_W'(out_rd), DATA_W'(e[RD_W-1:0]));
                end
            end
        end
    end

    initial begin
        reset = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        drive(1'b1, 128'hDEAD, 4'hF, 5'd31);

        // Reset held 3 cycles with in_valid high
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        drive(1'b0, '0, '0, '0);
        chk("rst_out_valid", DATA_W'(out_valid), '0);
        chk("rst_out_ctrl", DATA_W'(out_ctrl), '0);
        chk("rst_out_rd", DATA_W'(out_rd), '0);
        chk("rst_out_data", out_data, '0);
        chk("rst_occupancy", DATA_W'(occupancy), '0);
        chk("rst_in_ready", DATA_W'(in_ready), DATA_W'(1));
        chk_counters("rst", 32'd0, 16'd0);

        // Streaming at full rate
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, DATA_W'(i), 4'b1001, RD_W'(i + 2));
            step();
            chk("stream_valid", DATA_W'(out_valid), DATA_W'(1));
            chk("stream_data_latency", out_data, DATA_W'(i));
        end
        drive(1'b0, '0, '0, '0);
        step();
        chk("stream_drained", DATA_W'(out_valid), '0);
        step();

        // Back-pressure: A, B accepted, C held upstream
        out_ready = 1'b0;
        drive(1'b1, 128'hA, 4'b0011, 5'd11);
        step();
        chk("bp_occ_after_A", DATA_W'(occupancy), DATA_W'(1));
        chk("bp_ready_after_A", DATA_W'(in_ready), DATA_W'(1));
        drive(1'b1, 128'hB, 4'b0101, 5'd12);
        step();
        chk("bp_occ_after_B", DATA_W'(occupancy), DATA_W'(2));
        chk("bp_ready_after_B", DATA_W'(in_ready), '0);
        drive(1'b1, 128'hC, 4'b0111, 5'd13);
        step();
        step();
        chk("bp_occ_C_held", DATA_W'(occupancy), DATA_W'(2));
        chk("bp_out_still_A", out_data, 128'hA);
        chk_counters("bp", 32'd3, 16'd0);
        out_ready = 1'b1;
        step();
        chk("bp_out_B", out_data, 128'hB);
        step();
        chk("bp_out_C", out_data, 128'hC);
        drive(1'b0, '0, '0, '0);
        step();
        chk("bp_drained", DATA_W'(out_valid), '0);
        chk_counters("bp_end", 32'd3, 16'd0);

        // Flush while FULL with a new input offered
        out_ready = 1'b0;
        drive(1'b1, 128'hD, 4'b1111, 5'd20);
        step();
        drive(1'b1, 128'hE, 4'b1111, 5'd21);
        step();
        chk("fl_occ_full", DATA_W'(occupancy), DATA_W'(2));
        drive(1'b1, 128'hF, 4'b1111, 5'd22);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, '0, '0, '0);
        chk("fl_occ", DATA_W'(occupancy), '0);
        chk("fl_out_valid", DATA_W'(out_valid), '0);
        chk("fl_out_ctrl", DATA_W'(out_ctrl), '0);
        chk("fl_out_rd", DATA_W'(out_rd), '0);
        chk_counters("fl", 32'd5, 16'd2);
        step();
        chk("fl_input_dropped", DATA_W'(occupancy), '0);

        // Reset and flush together while FULL
        drive(1'b1, 128'h6, 4'b1001, 5'd6);
        step();
        drive(1'b1, 128'h7, 4'b1001, 5'd7);
        step();
        chk("rf_occ_full", DATA_W'(occupancy), DATA_W'(2));
        reset = 1'b0;
        flush = 1'b1;
        step();
        reset = 1'b1;
        flush = 1'b0;
        drive(1'b0, '0, '0, '0);
        chk("rf_occ", DATA_W'(occupancy), '0);
        chk("rf_out_valid", DATA_W'(out_valid), '0);
        chk("rf_in_ready", DATA_W'(in_ready), DATA_W'(1));
        chk("rf_out_data", out_data, '0);
        chk_counters("rf", 32'd0, 16'd0);

        // Stall counter saturation
        drive(1'b1, 128'h55, 4'b0001, 5'd9);
        step();
        drive(1'b0, '0, '0, '0);
`ifdef MEM_WB_PIPE_PERF_EN
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
`endif
        repeat (3) step();
        chk_counters("sat", 32'hFFFF_FFFF, 16'd0);
        out_ready = 1'b1;
        step();
        step();
        chk("end_occ", DATA_W'(occupancy), '0);
        chk("end_queue_empty", DATA_W'(sb.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded 20000 time units");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_wb_pipe_reg.md
Name: mem_wb_pipe_reg

Overview:
Parametrised MEM→WB pipeline stage register, the successor to the fixed-width, always-advancing MEM/WB latch. It adds a valid/ready handshake, a 2-entry skid buffer for full throughput under back-pressure, flush, and bubble zeroing of control. Payload is split into data, control and destination-register fields so the same block serves other stage boundaries.

Parameters:
DATA_W, 128, width of packed datapath payload (alu_out, mem_data, pc_imm, imm = 4×32).
CTRL_W, 4, width of packed control (reg_in_sel[1:0], mem_reg, reg_wr).
RD_W, 5, width of destination register index.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  synchronous, active-low reset (sampled on clk rising edge).
in_valid  in  1  upstream (MEM) entry valid.
in_ready  out  1  stage can accept; = ~skid_valid.
in_data  in  DATA_W  upstream payload.
in_ctrl  in  CTRL_W  upstream control.
in_rd  in  RD_W  upstream destination index.
flush  in  1  discard all held entries.
out_valid  out  1  WB entry valid.
out_ready  in  1  downstream (WB) accepts.
out_data  out  DATA_W  WB payload.
out_ctrl  out  CTRL_W  WB control; forced 0 when out_valid=0.
out_rd  out  RD_W  WB destination; forced 0 when out_valid=0.
occupancy  out  2  entries held: 0, 1 or 2.
stall_cnt  out  32  perf counter (see Optional Feature).
flush_drop_cnt  out  16  perf counter (see Optional Feature).

Behaviour:
- Storage: main register (drives outputs) + skid register. All state is registered; outputs come from the main register only.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- States: EMPTY (occ 0), ONE (main valid), FULL (main+skid valid).
- EMPTY: in_fire → ONE, main ← input. Latency is 1 cycle: input at edge N is visible at outputs after edge N.
- ONE: in_fire & out_fire → ONE, main ← input. in_fire only → FULL, skid ← input. out_fire only → EMPTY.
- FULL: in_ready=0, input ignored. out_fire → ONE, main ← skid. Otherwise hold.
- Order is strictly FIFO. No entry is duplicated or lost except by flush.
- out_valid=0 and out_ready=1 is legal and has no effect.
- flush=1 at an edge: next state EMPTY, both entries invalidated, any in_fire that cycle dropped. Flush takes priority over all handshake transitions.
- reset=0 at an edge: takes priority over flush. Next state EMPTY. All outputs read 0 except in_ready=1. Counters are cleared. Reset asserted mid-transfer discards held entries.
- Bubble rule: whenever out_valid=0, out_ctrl=0 and out_rd=0, so WB never writes. out_data may hold stale data.
- in_ready depends only on registered state, with no combinational path from out_ready.
- occupancy = main_valid + skid_valid.

Optional Feature:
Macro MEM_WB_PIPE_PERF_EN.
- Defined:
  - stall_cnt increments on every cycle with out_valid & ~out_ready, saturating at 0xFFFF_FFFF.
  - flush_drop_cnt adds occupancy (0–2) on each flush edge, saturating at 0xFFFF.
  - Both counters clear on reset.
- Not defined: both ports are tied to constant 0 and no counter logic is synthesised. The interface is unchanged.

Test Plan:
- Reset: hold reset=0 for 3 cycles with in_valid=1, then release → out_valid=0, out_ctrl=0, occupancy=0, in_ready=1, counters=0.
- Streaming: out_ready=1, present in_data=0x1..0x8 on consecutive cycles with ctrl=4'b1001, rd=5'd3..10 → each appears exactly 1 cycle later in order, one per cycle, no bubbles.
- Back-pressure: out_ready=0 while sending A, B, C → occupancy 1, then 2; in_ready=0 after B; C is held upstream. Raise out_ready → A, B, C emerge in order on consecutive cycles. stall_cnt equals the number of stall cycles (perf build).
- Flush with FULL: occupancy=2 and in_valid=1 with flush=1 → next cycle occupancy=0, out_valid=0, out_ctrl=0, out_rd=0, and the input is not captured. flush_drop_cnt increases by 2 (perf build).
- Reset vs flush: reset=0 and flush=1 together while FULL → reset values; flush_drop_cnt stays 0.
- Saturation (perf build): force stall_cnt to 0xFFFF_FFFE, stall 3 cycles → reads 0xFFFF_FFFF. Non-perf build: both counters read 0 throughout all scenarios.
